mult_seq_ctrl: RTL



---
 rtl/mult_seq_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add multiplier controller for MULT/MULTU. It drives an external
// 32-bit adder and owns sequencing, sign correction and carry-out reconstruction.
module mult_seq_ctrl #(
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] adder_a,
  output logic [31:0] adder_b,
  input  logic [31:0] adder_s,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    IDLE, ABS_A, ABS_B, ITER, NEG_LO, NEG_HI, DONE
  } state_t;

  state_t      state;
  logic [31:0] mcand;
  logic [4:0]  count;
  logic        neg;
  logic        signed_op;
  logic        c_lo;
  logic        cout;
  logic        use_signed;

  assign use_signed = SIGNED_EN && is_signed;

  // The adder has no carry-out port, so recover it from the operand and sum MSBs.
  assign cout = (adder_a[31] & adder_b[31]) |
                ((adder_a[31] ^ adder_b[31]) & ~adder_s[31]);

  always_comb begin
    // NOTE: default every output first so no path through the case infers a latch.
    adder_a = '0;
    adder_b = '0;
    case (state)
      ABS_A: begin
        adder_a = mcand[31] ? ~mcand : mcand;
        adder_b = {31'b0, mcand[31]};
      end
      ABS_B: begin
        adder_a = lo[31] ? ~lo : lo;
        adder_b = {31'b0, lo[31]};
      end
      ITER: begin
        adder_a = hi;
        adder_b = lo[0] ? mcand : '0;
      end
      NEG_LO: begin
        adder_a = neg ? ~lo : lo;
        adder_b = {31'b0, neg};
      end
      NEG_HI: begin
        adder_a = neg ? ~hi : hi;
        adder_b = {31'b0, neg & c_lo};
      end
      default: ;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register sees
  // the pre-edge values of the others, matching real flip-flop behaviour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mcand     <= '0;
      count     <= '0;
      neg       <= 1'b0;
      signed_op <= 1'b0;
      c_lo      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand     <= op_a;
            lo        <= op_b;
            hi        <= '0;
            count     <= '0;
            c_lo      <= 1'b0;
            signed_op <= use_signed;
            neg       <= use_signed & (op_a[31] ^ op_b[31]);
            busy      <= 1'b1;
            state     <= use_signed ? ABS_A : ITER;
          end
        end
        ABS_A: begin
          mcand <= adder_s;
          state <= ABS_B;
        end
        ABS_B: begin
          lo    <= adder_s;
          count <= '0;
          state <= ITER;
        end
        ITER: begin
          // Shift the 65-bit {cout, sum, lo} right by one; the multiplier bit falls off lo[0].
          hi    <= {cout, adder_s[31:1]};
          lo    <= {adder_s[0], lo[31:1]};
          count <= count + 5'd1;
          if (count == 5'd31) begin
            if (signed_op) begin
              state <= NEG_LO;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        NEG_LO: begin
          lo    <= adder_s;
          c_lo  <= neg && (lo == '0);
          state <= NEG_HI;
        end
        NEG_HI: begin
          hi    <= adder_s;
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
